pe_ctrl: RTL and testbench

PE_CTRL -- requirements
Module: pe_ctrl

---
 rtl/pe_ctrl.sv | 133 +++++++++++++
 tb/tb_pe_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_ctrl.sv
// pe_ctrl: sequencer for one neuron x weight dot-product pass.
// Clears the downstream accumulator, streams vec_len beats of operand reads from
// the neuron and weight buffers, marks the final multiplier beat, then holds
// result_vld until the consumer takes the result.
// Optional macro PE_CTRL_PERF_EN adds a saturating busy-cycle counter (perf_cnt).
module pe_ctrl #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  vec_len,
  input  logic [ADDR_W-1:0] nbase,
  input  logic [ADDR_W-1:0] wbase,
  output logic              sram_rd_en,
  output logic [ADDR_W-1:0] neuron_addr,
  output logic [ADDR_W-1:0] weight_addr,
  output logic              mult_vld,
  output logic              acc_clr,
  output logic              acc_last,
  output logic              result_vld,
  input  logic              result_rdy,
  output logic              busy
`ifdef PE_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_cnt
`endif
);

  typedef enum logic [2:0] {StIdle, StClr, StRead, StDrain, StDone} state_e;

  state_e             state_q;
  logic [LEN_W-1:0]   len_q;
  logic [ADDR_W-1:0]  nbase_q;
  logic [ADDR_W-1:0]  wbase_q;
  logic [LEN_W-1:0]   cnt_q;

  logic               cnt_last;
  logic [LEN_W-1:0]   cnt_inc;
  logic [ADDR_W-1:0]  off_inc;

  // Beat counter decode; cnt only counts to len-1, so len = 2^LEN_W-1 cannot overflow.
  always_comb begin
    cnt_last = (cnt_q == (len_q - LEN_W'(1)));
    cnt_inc  = cnt_q + LEN_W'(1);
    off_inc  = ADDR_W'(cnt_inc);
  end

  // Control FSM with all outputs registered; addresses hold their last value when idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      len_q       <= '0;
      nbase_q     <= '0;
      wbase_q     <= '0;
      cnt_q       <= '0;
      sram_rd_en  <= 1'b0;
      neuron_addr <= '0;
      weight_addr <= '0;
      mult_vld    <= 1'b0;
      acc_clr     <= 1'b0;
      acc_last    <= 1'b0;
      result_vld  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      // Operands arrive one cycle after the read.
      mult_vld <= sram_rd_en;
      acc_clr  <= 1'b0;
      acc_last <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            len_q   <= vec_len;
            nbase_q <= nbase;
            wbase_q <= wbase;
            cnt_q   <= '0;
            acc_clr <= 1'b1;
            busy    <= 1'b1;
            state_q <= StClr;
          end
        end
        StClr: begin
          if (len_q == '0) begin
            result_vld <= 1'b1;
            state_q    <= StDone;
          end else begin
            sram_rd_en  <= 1'b1;
            neuron_addr <= nbase_q;
            weight_addr <= wbase_q;
            state_q     <= StRead;
          end
        end
        StRead: begin
          if (cnt_last) begin
            sram_rd_en <= 1'b0;
            // Lines up with the mult_vld of this final read.
            acc_last   <= 1'b1;
            state_q    <= StDrain;
          end else begin
            cnt_q       <= cnt_inc;
            neuron_addr <= nbase_q + off_inc;
            weight_addr <= wbase_q + off_inc;
          end
        end
        StDrain: begin
          result_vld <= 1'b1;
          state_q    <= StDone;
        end
        StDone: begin
          if (result_rdy) begin
            result_vld <= 1'b0;
            busy       <= 1'b0;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef PE_CTRL_PERF_EN
  // Busy-cycle counter, saturating, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_cnt <= '0;
    end else if (busy && (perf_cnt != 32'hFFFF_FFFF)) begin
      perf_cnt <= perf_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pe_ctrl.sv
// Randomized scoreboard bench for pe_ctrl: the driver pushes the expected reads and
// operation timing into queues, a negedge monitor pops and compares them.
module tb_pe_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] vec_len;
  logic [7:0] nbase;
  logic [7:0] wbase;
  logic       sram_rd_en;
  logic [7:0] neuron_addr;
  logic [7:0] weight_addr;
  logic       mult_vld;
  logic       acc_clr;
  logic       acc_last;
  logic       result_vld;
  logic       result_rdy;
  logic       busy;
`ifdef PE_CTRL_PERF_EN
  logic [31:0] perf_cnt;
`endif

  pe_ctrl #(.ADDR_W(8), .LEN_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .vec_len     (vec_len),
    .nbase       (nbase),
    .wbase       (wbase),
    .sram_rd_en  (sram_rd_en),
    .neuron_addr (neuron_addr),
    .weight_addr (weight_addr),
    .mult_vld    (mult_vld),
    .acc_clr     (acc_clr),
    .acc_last    (acc_last),
    .result_vld  (result_vld),
    .result_rdy  (result_rdy),
    .busy        (busy)
`ifdef PE_CTRL_PERF_EN
    ,
    .perf_cnt    (perf_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {logic [7:0] n; logic [7:0] w;} rd_t;
  typedef struct {int len; int start_cyc;} op_t;
  rd_t exp_rd[$];
  op_t exp_op[$];

  function automatic void chk(input string name, input longint got, input longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", name, got, want, cyc);
    end
  endfunction

  // Monitor: pops expectations whenever the DUT shows activity.
  logic prev_rd = 1'b0, prev_vld = 1'b0, prev_hs = 1'b0;
  int   rd_n = 0, mv_n = 0, clr_n = 0;
  always @(negedge clk) begin
    rd_t e;
    op_t cur;
    if (!rst_n) begin
      exp_rd.delete();
      exp_op.delete();
      prev_rd = 1'b0; prev_vld = 1'b0; prev_hs = 1'b0;
      rd_n = 0; mv_n = 0; clr_n = 0;
    end else begin
      chk("mult_vld_follows_rd", mult_vld, prev_rd);
      if (exp_op.size() == 0) begin
        chk("idle_quiet", {acc_clr, sram_rd_en, mult_vld, acc_last, result_vld}, 0);
      end else begin
        cur = exp_op[0];
        if (acc_clr) begin
          chk("acc_clr_cycle", cyc - cur.start_cyc, 1);
          clr_n++;
        end
        if (sram_rd_en) begin
          if (exp_rd.size() == 0) begin
            chk("rd_unexpected", 1, 0);
          end else begin
            e = exp_rd.pop_front();
            chk("neuron_addr", neuron_addr, e.n);
            chk("weight_addr", weight_addr, e.w);
            chk("rd_cycle", cyc - cur.start_cyc, 2 + rd_n);
          end
          rd_n++;
        end
        if (mult_vld || acc_last)
          chk("acc_last", acc_last, (mult_vld && (mv_n + 1 == cur.len)) ? 1 : 0);
        if (mult_vld) mv_n++;
        if (result_vld && !prev_vld)
          chk("result_latency", cyc - cur.start_cyc, (cur.len == 0) ? 2 : cur.len + 3);
        if (result_vld && result_rdy) begin
          chk("reads_done", rd_n, cur.len);
          chk("mult_beats", mv_n, cur.len);
          chk("acc_clr_once", clr_n, 1);
          void'(exp_op.pop_front());
          rd_n = 0; mv_n = 0; clr_n = 0;
        end
      end
      if (prev_vld && !prev_hs) chk("result_vld_held", result_vld, 1);
      prev_rd  = sram_rd_en;
      prev_vld = result_vld;
      prev_hs  = result_vld && result_rdy;
    end
  end

  task automatic wait_idle();
    int guard = 0;
    while (busy && guard < 1000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (busy) chk("idle_timeout", busy, 0);
  endtask

  task automatic launch(input int len, input logic [7:0] nb, input logic [7:0] wb);
    rd_t e;
    start   = 1'b1;
    vec_len = 8'(len);
    nbase   = nb;
    wbase   = wb;
    exp_op.push_back('{len: len, start_cyc: cyc});
    for (int i = 0; i < len; i++) begin
      e.n = nb + 8'(i);
      e.w = wb + 8'(i);
      exp_rd.push_back(e);
    end
    @(posedge clk); #1;
    start   = 1'b0;
    vec_len = 8'($urandom);
    nbase   = 8'($urandom);
    wbase   = 8'($urandom);
  endtask

  // One full operation; optional stray starts during the run and at the handshake.
  task automatic issue(input int len, input logic [7:0] nb, input logic [7:0] wb,
                       input int rdy_dly, input bit stray);
    int guard = 0;
    wait_idle();
    launch(len, nb, wb);
    while (!result_vld && guard < 600) begin
      start = (stray && guard == 2);
      @(posedge clk); #1;
      guard++;
    end
    start = 1'b0;
    if (!result_vld) begin
      chk("result_timeout", result_vld, 1);
    end else begin
      repeat (rdy_dly) begin
        @(posedge clk); #1;
      end
      result_rdy = 1'b1;
      start      = stray;
      @(posedge clk); #1;
      result_rdy = 1'b0;
      start      = 1'b0;
      chk("busy_drop", busy, 0);
      chk("result_vld_drop", result_vld, 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] nb;
    int guard;
    rst_n = 1'b0; start = 1'b0; result_rdy = 1'b0;
    vec_len = '0; nbase = '0; wbase = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {sram_rd_en, mult_vld, acc_clr, acc_last, result_vld, busy,
                          neuron_addr, weight_addr}, 0);
`ifdef PE_CTRL_PERF_EN
    chk("perf_reset", perf_cnt, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(4, 8'h10, 8'h80, 0, 1'b0);
    issue(0, 8'h33, 8'h44, 1, 1'b0);
    issue(3, 8'hFE, 8'h20, 1, 1'b0);
    issue(6, 8'h05, 8'hF0, 5, 1'b1);
    issue(255, 8'($urandom), 8'($urandom), 2, 1'b0);
    for (int k = 0; k < 12; k++)
      issue(int'($urandom_range(0, 20)), 8'($urandom), 8'($urandom),
            int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));

    // Abort mid-READ while the cnt=2 read is on the bus.
    wait_idle();
    nb = 8'h40;
    launch(8, nb, 8'h90);
    guard = 0;
    while (!(sram_rd_en && neuron_addr == nb + 8'd2) && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("abort_reached_cnt2", neuron_addr, nb + 8'd2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_outputs", {sram_rd_en, mult_vld, acc_clr, acc_last, result_vld, busy,
                          neuron_addr, weight_addr}, 0);
`ifdef PE_CTRL_PERF_EN
    chk("perf_after_abort", perf_cnt, 0);
`endif
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    issue(1, 8'h7F, 8'h01, 0, 1'b0);
`ifdef PE_CTRL_PERF_EN
    chk("perf_len1", perf_cnt, 4);
`endif
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("ops_drained", exp_op.size(), 0);
    chk("reads_drained", exp_rd.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
